// File: rtl/prog_loader.sv
// Switch-driven loader for the 16-word instruction RAM of the 4-bit Go Board CPU.
// Each instruction is built as two nibbles: SW3 steps the nibble value and SW2 enters it.
// Completed words go out as single-cycle writes to sequential addresses.
// SW4 finishes loading. All button events are ignored while the CPU is running.
module prog_loader #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEPTH       = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SW2,
   input  logic       SW3,
   input  logic       SW4,
   input  logic       cpu_running,
   output logic       mem_we,
   output logic [3:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic [3:0] led_out,
   output logic       load_done,
   output logic       mem_full
);

   localparam int unsigned AW   = 4;
   localparam int unsigned NW   = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned NBTN = 3;

   // Button bit positions inside the synchroniser vectors
   localparam int unsigned B_ENTER = 0;
   localparam int unsigned B_INC   = 1;
   localparam int unsigned B_FIN   = 2;

   typedef enum logic [1:0] {
      EDIT_HI = 2'd0,
      EDIT_LO = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Button synchronisers and rising-edge event registers
   logic [NBTN-1:0] sync_q [SYNC_STAGES];
   logic [NBTN-1:0] prev_q;
   logic [NBTN-1:0] ev_q;

   // FSM and datapath registers
   state_t          state_q, state_nxt;
   logic [NW-1:0]   nib_q,   nib_nxt;
   logic [NW-1:0]   hi_q,    hi_nxt;
   logic [AW-1:0]   ptr_q,   ptr_nxt;
   logic            we_q,    we_nxt;
   logic [AW-1:0]   addr_q,  addr_nxt;
   logic [DW-1:0]   wdata_q, wdata_nxt;
   logic [NW-1:0]   led_q,   led_nxt;
   logic            done_q,  done_nxt;
   logic            full_q,  full_nxt;

   // Qualified events; dropping them while the CPU runs freezes the editor
   logic            act_enter_c, act_inc_c, act_fin_c;

   // Synchronise the buttons and register a one-cycle pulse on each rising level
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '{default: '0};
         prev_q <= '0;
         ev_q   <= '0;
      end else begin
         sync_q[0] <= {SW4, SW3, SW2};
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
         ev_q   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign act_fin_c   = ev_q[B_FIN]   & ~cpu_running;
   assign act_enter_c = ev_q[B_ENTER] & ~cpu_running;
   assign act_inc_c   = ev_q[B_INC]   & ~cpu_running;

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= EDIT_HI;
         nib_q   <= '0;
         hi_q    <= '0;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         led_q   <= '0;
         done_q  <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         nib_q   <= nib_nxt;
         hi_q    <= hi_nxt;
         ptr_q   <= ptr_nxt;
         we_q    <= we_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         led_q   <= led_nxt;
         done_q  <= done_nxt;
         full_q  <= full_nxt;
      end
   end

   // Next-state logic; priority is fin > enter > inc and only the winner acts
   always_comb begin
      state_nxt = state_q;
      nib_nxt   = nib_q;
      hi_nxt    = hi_q;
      ptr_nxt   = ptr_q;
      we_nxt    = 1'b0;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      done_nxt  = done_q;
      full_nxt  = full_q;

      unique case (state_q)
         EDIT_HI: begin
            if (act_fin_c) begin
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (act_enter_c) begin
               hi_nxt    = nib_q;
               nib_nxt   = '0;
               state_nxt = EDIT_LO;
            end else if (act_inc_c) begin
               nib_nxt   = nib_q + NW'(1);
            end
         end
         EDIT_LO: begin
            // A pending opcode nibble is simply abandoned on finish
            if (act_fin_c) begin
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (act_enter_c) begin
               we_nxt    = 1'b1;
               addr_nxt  = ptr_q;
               wdata_nxt = {hi_q, nib_q};
               state_nxt = WRITE;
            end else if (act_inc_c) begin
               nib_nxt   = nib_q + NW'(1);
            end
         end
         WRITE: begin
            // Strobe lasts one cycle regardless of events or cpu_running
            ptr_nxt = ptr_q + AW'(1);
            nib_nxt = '0;
            if (addr_q == AW'(DEPTH - 1)) begin
               full_nxt  = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end else begin
               state_nxt = EDIT_HI;
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = EDIT_HI;
         end
      endcase
   end

   // LED value follows the state being entered so it is registered with it
   always_comb begin
      led_nxt = '0;
      unique case (state_nxt)
         EDIT_HI, EDIT_LO: led_nxt = nib_nxt;
         WRITE:            led_nxt = wdata_nxt[NW-1:0];
         DONE:             led_nxt = ptr_nxt;
         default:          led_nxt = '0;
      endcase
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign led_out   = led_q;
   assign load_done = done_q;
   assign mem_full  = full_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned DEPTH       = 16;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SW2 = 1'b0;
   logic       SW3 = 1'b0;
   logic       SW4 = 1'b0;
   logic       cpu_running = 1'b0;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [3:0] led_out;
   logic       load_done;
   logic       mem_full;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0] wa_q [$];
   logic [7:0] wd_q [$];

   prog_loader #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEPTH       (DEPTH)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .SW2         (SW2),
      .SW3         (SW3),
      .SW4         (SW4),
      .cpu_running (cpu_running),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .led_out     (led_out),
      .load_done   (load_done),
      .mem_full    (mem_full)
   );

   always #5 CLK = ~CLK;

   // Log every write the RAM would sample
   always @(negedge CLK) begin
      if (mem_we === 1'b1) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // b = {SW4, SW3, SW2}; holds long enough to be seen, releases long enough to re-arm
   task automatic press(input logic [2:0] b);
      SW2 = b[0]; SW3 = b[1]; SW4 = b[2];
      tick(2);
      SW2 = 1'b0; SW3 = 1'b0; SW4 = 1'b0;
      tick(3);
   endtask

   task automatic press_n(input logic [2:0] b, input int n);
      for (int i = 0; i < n; i++) press(b);
   endtask

   task automatic enter_word(input int hi, input int lo);
      press_n(3'b010, hi);
      press(3'b001);
      press_n(3'b010, lo);
      press(3'b001);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      SW2 = 1'b0; SW3 = 1'b0; SW4 = 1'b0;
      cpu_running = 1'b0;
      tick(2);
      RST = 1'b0;
      tick(1);
      wa_q.delete();
      wd_q.delete();
   endtask

   initial begin
      int we_k;
      logic [3:0] led_w;
      logic [3:0] h, l;

      // Reset defaults
      do_reset();
      tick(2);
      check("rst_we",    32'(mem_we),    32'd0);
      check("rst_addr",  32'(mem_addr),  32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_led",   32'(led_out),   32'd0);
      check("rst_done",  32'(load_done), 32'd0);
      check("rst_full",  32'(mem_full),  32'd0);

      // Single word 0x35 with write-strobe latency measured from the SW2 rise
      press_n(3'b010, 3);
      check("sw_led_hi", 32'(led_out), 32'd3);
      press(3'b001);
      check("sw_led_clr", 32'(led_out), 32'd0);
      press_n(3'b010, 5);
      check("sw_led_lo", 32'(led_out), 32'd5);
      we_k  = 0;
      led_w = '0;
      SW2   = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge CLK); #1;
         if (k == 2) SW2 = 1'b0;
         if (mem_we === 1'b1 && we_k == 0) begin
            we_k  = k;
            led_w = led_out;
         end
      end
      // Sampled at edge n, event at n+S, strobe visible after edge n+S+1
      check("sw_latency", 32'(we_k), 32'(SYNC_STAGES + 2));
      check("sw_led_wr",  32'(led_w), 32'd5);
      check("sw_nwr",     32'(wa_q.size()), 32'd1);
      if (wa_q.size() > 0) begin
         check("sw_addr",  32'(wa_q[0]), 32'd0);
         check("sw_wdata", 32'(wd_q[0]), 32'h35);
      end
      check("sw_led_after", 32'(led_out), 32'd0);
      check("sw_we_low",    32'(mem_we),  32'd0);

      // Nibble wrap: 17 increments gives 1
      press_n(3'b010, 17);
      check("wrap_led", 32'(led_out), 32'd1);

      // Full memory: word i = {i, 15-i}
      do_reset();
      for (int i = 0; i < 16; i++) enter_word(i, 15 - i);
      check("full_nwr", 32'(wa_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
         h = 4'(i);
         l = 4'(15 - i);
         check($sformatf("full_addr%0d", i), 32'(wa_q[i]), 32'(i));
         check($sformatf("full_data%0d", i), 32'(wd_q[i]), 32'({h, l}));
      end
      check("full_full", 32'(mem_full),  32'd1);
      check("full_done", 32'(load_done), 32'd1);
      check("full_led",  32'(led_out),   32'd0);
      press(3'b001);
      press(3'b010);
      press(3'b001);
      check("full_nomore", 32'(wa_q.size()), 32'd16);
      check("full_led2",   32'(led_out),     32'd0);

      // Early finish after a half-entered third word
      do_reset();
      enter_word(1, 2);
      enter_word(3, 4);
      press_n(3'b010, 2);
      press(3'b001);
      press(3'b100);
      check("early_nwr",  32'(wa_q.size()), 32'd2);
      check("early_done", 32'(load_done),   32'd1);
      check("early_full", 32'(mem_full),    32'd0);
      check("early_led",  32'(led_out),     32'd2);

      // Interlock: buttons ignored while the CPU runs, state resumes afterwards
      do_reset();
      press_n(3'b010, 2);
      cpu_running = 1'b1;
      press_n(3'b010, 3);
      press(3'b001);
      press(3'b001);
      check("lock_led", 32'(led_out),     32'd2);
      check("lock_nwr", 32'(wa_q.size()), 32'd0);
      cpu_running = 1'b0;
      press(3'b001);
      press(3'b010);
      press(3'b001);
      check("lock_nwr2", 32'(wa_q.size()), 32'd1);
      if (wd_q.size() > 0) check("lock_data", 32'(wd_q[0]), 32'h21);

      // Priority enter over inc: hi captured as 3, nibble not incremented
      do_reset();
      press_n(3'b010, 3);
      press(3'b011);
      check("pri_ei_led", 32'(led_out), 32'd0);
      press(3'b001);
      check("pri_ei_nwr", 32'(wa_q.size()), 32'd1);
      if (wd_q.size() > 0) check("pri_ei_data", 32'(wd_q[0]), 32'h30);

      // Priority fin over enter in EDIT_LO: no write, finished
      do_reset();
      press(3'b010);
      press(3'b001);
      press(3'b101);
      check("pri_fe_nwr",  32'(wa_q.size()), 32'd0);
      check("pri_fe_done", 32'(load_done),   32'd1);
      check("pri_fe_led",  32'(led_out),     32'd0);
      press(3'b001);
      check("pri_fe_nwr2", 32'(wa_q.size()), 32'd0);

      // Reset during the write cycle
      do_reset();
      press(3'b010);
      press(3'b001);
      press(3'b010);
      we_k = 0;
      SW2  = 1'b1;
      for (int k = 1; k <= 8 && we_k == 0; k++) begin
         @(posedge CLK); #1;
         if (k == 2) SW2 = 1'b0;
         if (mem_we === 1'b1) we_k = k;
      end
      check("mw_seen", 32'(we_k != 0), 32'd1);
      RST = 1'b1;
      SW2 = 1'b0;
      tick(1);
      check("mw_we",   32'(mem_we),    32'd0);
      check("mw_addr", 32'(mem_addr),  32'd0);
      check("mw_led",  32'(led_out),   32'd0);
      check("mw_done", 32'(load_done), 32'd0);
      RST = 1'b0;
      tick(1);
      wa_q.delete();
      wd_q.delete();
      enter_word(4, 6);
      check("mw_nwr", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() > 0) begin
         check("mw_ptr0", 32'(wa_q[0]), 32'd0);
         check("mw_data", 32'(wd_q[0]), 32'h46);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
